// File: rtl/sdr_init_refresh_seq.sv
// SDRAM power-up sequencer and periodic refresh scheduler.
// Drives the command bus during init and refresh; hands it back to the core in IDLE.
module sdr_init_refresh_seq #(
  parameter int          SDR_BW       = 2,
  parameter int          T_INIT       = 10000,
  parameter int          T_RP         = 2,
  parameter int          T_RFC        = 7,
  parameter int          T_MRD        = 2,
  parameter int          NUM_INIT_REF = 8,
  parameter int          REF_INTERVAL = 780,
  parameter logic [12:0] MODE_REG     = 13'h033,
  parameter int          CNT_W        = 16
) (
  input  logic              sdram_clk,
  input  logic              sdram_reset,
  output logic              sdr_cke,
  output logic              sdr_cs_n,
  output logic              sdr_ras_n,
  output logic              sdr_cas_n,
  output logic              sdr_we_n,
  output logic [1:0]        sdr_ba,
  output logic [12:0]       sdr_addr,
  output logic [SDR_BW-1:0] sdr_dqm,
  output logic              cmd_own,
  output logic              init_done,
  output logic              ref_req,
  input  logic              ref_gnt,
  output logic [3:0]        ref_pending,
  output logic              ref_overrun
);

  localparam int REF_W = $clog2(NUM_INIT_REF + 1);

  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(T_INIT);
  localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RFC_LAST  = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] MRD_LAST  = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(REF_INTERVAL - 1);
  localparam logic [REF_W-1:0] INIT_REFS = REF_W'(NUM_INIT_REF);

  localparam logic [3:0] CMD_LMR  = 4'b0000;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_NOP  = 4'b0111;

  typedef enum logic [3:0] {
    WAIT_INIT,
    PRE_ALL,
    WAIT_RP,
    INIT_AREF,
    WAIT_RFC,
    LOAD_MODE,
    WAIT_MRD,
    IDLE,
    REF_PRE,
    REF_WAIT_RP,
    REF_AREF,
    REF_WAIT_RFC
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0] ref_timer, ref_timer_nxt;
  logic [REF_W-1:0] aref_cnt, aref_cnt_nxt;
  logic [3:0]       pending_nxt;
  logic             overrun_nxt;
  logic             init_done_nxt;
  logic             ref_req_nxt;
  logic             tick;
  logic             aref_dec;
  logic             in_wait;
  logic [3:0]       cmd_nxt;
  logic [12:0]      addr_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_INIT:    if (timer == INIT_LAST) state_nxt = PRE_ALL;
      PRE_ALL:      state_nxt = WAIT_RP;
      WAIT_RP:      if (timer == RP_LAST) state_nxt = INIT_AREF;
      INIT_AREF:    state_nxt = WAIT_RFC;
      WAIT_RFC: begin
        if (timer == RFC_LAST) begin
          if (aref_cnt == INIT_REFS) state_nxt = LOAD_MODE;
          else                       state_nxt = INIT_AREF;
        end
      end
      LOAD_MODE:    state_nxt = WAIT_MRD;
      WAIT_MRD:     if (timer == MRD_LAST) state_nxt = IDLE;
      IDLE:         if (ref_req && ref_gnt) state_nxt = REF_PRE;
      REF_PRE:      state_nxt = REF_WAIT_RP;
      REF_WAIT_RP:  if (timer == RP_LAST) state_nxt = REF_AREF;
      REF_AREF:     state_nxt = REF_WAIT_RFC;
      REF_WAIT_RFC: if (timer == RFC_LAST) state_nxt = IDLE;
      default:      state_nxt = WAIT_INIT;
    endcase
  end

  // The state timer restarts at 1 on every transition, so a wait state leaves
  // once it has spent T_x-1 cycles and the next command lands exactly T_x later.
  always_comb begin
    in_wait = (state == WAIT_INIT) || (state == WAIT_RP) || (state == WAIT_RFC) ||
              (state == WAIT_MRD) || (state == REF_WAIT_RP) || (state == REF_WAIT_RFC);
    timer_nxt = timer;
    if (state_nxt != state) timer_nxt = CNT_W'(1);
    else if (in_wait)       timer_nxt = timer + CNT_W'(1);

    aref_cnt_nxt = aref_cnt;
    if (state == INIT_AREF) aref_cnt_nxt = aref_cnt + REF_W'(1);
  end

  always_comb begin
    tick          = 1'b0;
    ref_timer_nxt = ref_timer;
    if (!init_done) begin
      ref_timer_nxt = '0;
    end else if (ref_timer == TICK_LAST) begin
      ref_timer_nxt = '0;
      tick          = 1'b1;
    end else begin
      ref_timer_nxt = ref_timer + CNT_W'(1);
    end

    // A tick coinciding with a refresh AREF cancels out.
    aref_dec    = (state_nxt == REF_AREF);
    pending_nxt = ref_pending;
    overrun_nxt = ref_overrun;
    if (tick && !aref_dec) begin
      if (ref_pending == 4'd8) overrun_nxt = 1'b1;
      else                     pending_nxt = ref_pending + 4'd1;
    end else if (!tick && aref_dec && ref_pending != 4'd0) begin
      pending_nxt = ref_pending - 4'd1;
    end

    init_done_nxt = init_done || (state_nxt == IDLE);
    ref_req_nxt   = init_done_nxt && (pending_nxt != 4'd0) && (state_nxt == IDLE);
  end

  always_comb begin
    cmd_nxt  = CMD_NOP;
    addr_nxt = 13'h0000;
    case (state_nxt)
      PRE_ALL, REF_PRE: begin
        cmd_nxt  = CMD_PRE;
        addr_nxt = 13'h0400;
      end
      INIT_AREF, REF_AREF: cmd_nxt = CMD_AREF;
      LOAD_MODE: begin
        cmd_nxt  = CMD_LMR;
        addr_nxt = MODE_REG;
      end
      default: begin
        cmd_nxt  = CMD_NOP;
        addr_nxt = 13'h0000;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so each pin value lines
  // up with the state that owns that cycle.
  always_ff @(posedge sdram_clk) begin
    if (sdram_reset) begin
      state       <= WAIT_INIT;
      timer       <= '0;
      ref_timer   <= '0;
      aref_cnt    <= '0;
      ref_pending <= 4'd0;
      ref_overrun <= 1'b0;
      init_done   <= 1'b0;
      ref_req     <= 1'b0;
      cmd_own     <= 1'b1;
      sdr_cke     <= 1'b0;
      {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_NOP;
      sdr_ba      <= 2'b00;
      sdr_addr    <= 13'h0000;
      sdr_dqm     <= '1;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      ref_timer   <= ref_timer_nxt;
      aref_cnt    <= aref_cnt_nxt;
      ref_pending <= pending_nxt;
      ref_overrun <= overrun_nxt;
      init_done   <= init_done_nxt;
      ref_req     <= ref_req_nxt;
      cmd_own     <= (state_nxt != IDLE);
      sdr_cke     <= 1'b1;
      {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= cmd_nxt;
      sdr_ba      <= 2'b00;
      sdr_addr    <= addr_nxt;
      sdr_dqm     <= '1;
    end
  end

endmodule

// File: tb/tb_sdr_init_refresh_seq.sv
// Directed bench for sdr_init_refresh_seq: init sequence, refresh handshake,
// mid-refresh reset and pending saturation/overrun, with shortened timings.
module tb_sdr_init_refresh_seq;

  localparam int SDR_BW       = 2;
  localparam int T_INIT       = 20;
  localparam int T_RP         = 2;
  localparam int T_RFC        = 4;
  localparam int T_MRD        = 2;
  localparam int NUM_INIT_REF = 2;
  localparam int REF_INTERVAL = 50;

  localparam logic [3:0] C_LMR  = 4'b0000;
  localparam logic [3:0] C_AREF = 4'b0001;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_NOP  = 4'b0111;

  logic              sdram_clk = 1'b0;
  logic              sdram_reset;
  logic              ref_gnt;
  logic              sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
  logic [1:0]        sdr_ba;
  logic [12:0]       sdr_addr;
  logic [SDR_BW-1:0] sdr_dqm;
  logic              cmd_own, init_done, ref_req, ref_overrun;
  logic [3:0]        ref_pending;
  logic [3:0]        cmd;

  int cyc;
  int n_checks;
  int n_fails;

  assign cmd = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};

  always #5 sdram_clk = ~sdram_clk;

  sdr_init_refresh_seq #(
    .SDR_BW(SDR_BW), .T_INIT(T_INIT), .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD),
    .NUM_INIT_REF(NUM_INIT_REF), .REF_INTERVAL(REF_INTERVAL),
    .MODE_REG(13'h033), .CNT_W(16)
  ) dut (
    .sdram_clk(sdram_clk), .sdram_reset(sdram_reset),
    .sdr_cke(sdr_cke), .sdr_cs_n(sdr_cs_n), .sdr_ras_n(sdr_ras_n),
    .sdr_cas_n(sdr_cas_n), .sdr_we_n(sdr_we_n), .sdr_ba(sdr_ba),
    .sdr_addr(sdr_addr), .sdr_dqm(sdr_dqm), .cmd_own(cmd_own),
    .init_done(init_done), .ref_req(ref_req), .ref_gnt(ref_gnt),
    .ref_pending(ref_pending), .ref_overrun(ref_overrun)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fails++;
      $error("[TB] FAIL %s (cycle %0d): observed 0x%0h, expected 0x%0h",
             tag, cyc, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic gnt);
    sdram_reset = rst;
    ref_gnt     = gnt;
  endtask

  task automatic next_cycle();
    @(negedge sdram_clk);
    cyc++;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) next_cycle();
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, " cmd/addr"}, 32'({cmd, sdr_addr}), 32'({C_NOP, 13'h0000}));
    checkOutput({tag, " cke/ba/dqm"}, 32'({sdr_cke, sdr_ba, sdr_dqm}),
                32'({1'b0, 2'b00, {SDR_BW{1'b1}}}));
    checkOutput({tag, " own/done/req/ovr"},
                32'({cmd_own, init_done, ref_req, ref_overrun}), 32'(4'b1000));
    checkOutput({tag, " pending"}, 32'(ref_pending), 32'(4'd0));
  endtask

  // Cycles 0..32 after reset release, with grant pulses that must be ignored.
  task automatic check_init_sequence();
    logic [3:0]  exp_cmd;
    logic [12:0] exp_addr;
    for (int c = 0; c <= 32; c++) begin
      wait_until(c);
      exp_cmd  = C_NOP;
      exp_addr = 13'h0000;
      if (c == 20) begin
        exp_cmd  = C_PRE;
        exp_addr = 13'h0400;
      end else if (c == 22 || c == 26) begin
        exp_cmd  = C_AREF;
      end else if (c == 30) begin
        exp_cmd  = C_LMR;
        exp_addr = 13'h0033;
      end
      checkOutput("init cmd/addr", 32'({cmd, sdr_addr}), 32'({exp_cmd, exp_addr}));
      checkOutput("init cke/ba/dqm", 32'({sdr_cke, sdr_ba, sdr_dqm}),
                  32'({1'b1, 2'b00, {SDR_BW{1'b1}}}));
      checkOutput("init own/done/req", 32'({cmd_own, init_done, ref_req}),
                  32'({(c < 32), (c >= 32), 1'b0}));
      applyStimulus(1'b0, (c == 5 || c == 21 || c == 28));
    end
    applyStimulus(1'b0, 1'b0);
  endtask

  // One granted refresh starting at cycle g, with a stray grant during WAIT_RP.
  task automatic check_refresh(input int g, input logic [3:0] pend);
    logic [3:0]  exp_cmd;
    logic [12:0] exp_addr;
    logic [3:0]  exp_pend;
    wait_until(g);
    checkOutput("req/pending at grant", 32'({ref_req, ref_pending}), 32'({1'b1, pend}));
    applyStimulus(1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      wait_until(g + k);
      exp_cmd  = (k == 1) ? C_PRE : ((k == 3) ? C_AREF : C_NOP);
      exp_addr = (k == 1) ? 13'h0400 : 13'h0000;
      exp_pend = (k < 3) ? pend : (pend - 4'd1);
      checkOutput("refresh cmd/addr", 32'({cmd, sdr_addr}), 32'({exp_cmd, exp_addr}));
      checkOutput("refresh own/req", 32'({cmd_own, ref_req}),
                  32'({(k < 7), ((k == 7) && (pend != 4'd1))}));
      checkOutput("refresh pending", 32'(ref_pending), 32'(exp_pend));
      applyStimulus(1'b0, (k == 2));
    end
    applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    cyc      = -100;

    applyStimulus(1'b1, 1'b0);
    repeat (3) @(negedge sdram_clk);
    check_reset_values("reset");

    applyStimulus(1'b0, 1'b0);
    cyc = -1;
    check_init_sequence();

    wait_until(81);
    checkOutput("req/pending before first tick", 32'({ref_req, ref_pending}), 32'({1'b0, 4'd0}));
    check_refresh(82, 4'd1);

    wait_until(131);
    checkOutput("pending idle after refresh", 32'({ref_req, ref_pending}), 32'({1'b0, 4'd0}));
    wait_until(132);
    checkOutput("second tick", 32'({ref_req, ref_pending}), 32'({1'b1, 4'd1}));

    check_refresh(182, 4'd2);
    check_refresh(189, 4'd1);

    wait_until(231);
    checkOutput("idle after back-to-back", 32'({ref_req, ref_pending, cmd_own}),
                32'({1'b0, 4'd0, 1'b0}));

    wait_until(282);
    checkOutput("req before reset scenario", 32'({ref_req, ref_pending}), 32'({1'b1, 4'd2}));
    applyStimulus(1'b0, 1'b1);
    wait_until(283);
    checkOutput("reset scen PRE", 32'({cmd, sdr_addr}), 32'({C_PRE, 13'h0400}));
    applyStimulus(1'b0, 1'b0);
    wait_until(285);
    checkOutput("reset scen AREF", 32'({cmd, ref_pending}), 32'({C_AREF, 4'd1}));
    wait_until(286);
    checkOutput("reset scen WAIT_RFC", 32'({cmd, cmd_own, init_done}), 32'({C_NOP, 1'b1, 1'b1}));
    applyStimulus(1'b1, 1'b0);
    wait_until(287);
    check_reset_values("mid-refresh reset");

    applyStimulus(1'b0, 1'b0);
    cyc = -1;
    check_init_sequence();

    wait_until(81);
    checkOutput("no tick yet after reinit", 32'({ref_req, ref_pending}), 32'({1'b0, 4'd0}));
    wait_until(82);
    checkOutput("first tick after reinit", 32'({ref_req, ref_pending}), 32'({1'b1, 4'd1}));
    wait_until(431);
    checkOutput("pending 7", 32'({ref_overrun, ref_pending}), 32'({1'b0, 4'd7}));
    wait_until(432);
    checkOutput("pending 8", 32'({ref_overrun, ref_pending}), 32'({1'b0, 4'd8}));
    wait_until(481);
    checkOutput("saturated no overrun", 32'({ref_overrun, ref_pending}), 32'({1'b0, 4'd8}));
    wait_until(482);
    checkOutput("overrun set", 32'({ref_overrun, ref_pending}), 32'({1'b1, 4'd8}));
    wait_until(532);
    checkOutput("overrun sticky", 32'({ref_overrun, ref_pending, ref_req, cmd_own}),
                32'({1'b1, 4'd8, 1'b1, 1'b0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sdr_init_refresh_seq.md
Name: sdr_init_refresh_seq

Overview:
- Command-source stage directly upstream of the SDRAM pin bus. It drives cke/cs_n/ras_n/cas_n/we_n/ba/addr/dqm into the controller's command mux.
- Runs the JEDEC power-up sequence: wait, PRECHARGE ALL, N AUTO REFRESH, LOAD MODE REGISTER.
- After power-up it schedules periodic refresh, using a request/grant handshake with the core arbiter.
- Every command it emits is legal for the bank-state checker on the bus interface (all banks idle before AREF/LMR).

Parameters:
SDR_BW, 2, SDRAM byte width (width of dqm)
T_INIT, 10000, power-up NOP cycles before first command
T_RP, 2, PRECHARGE-to-next-command cycles (>=2)
T_RFC, 7, AUTO REFRESH-to-next-command cycles (>=2)
T_MRD, 2, LMR-to-next-command cycles (>=2)
NUM_INIT_REF, 8, AUTO REFRESH count during init (>=1)
REF_INTERVAL, 780, cycles between refresh ticks
MODE_REG, 13'h033, value driven on sdr_addr with LMR (BL8, CL3)
CNT_W, 16, timer width; must hold max(T_INIT, REF_INTERVAL)

Ports:
sdram_clk  in  1  SDRAM clock
sdram_reset  in  1  synchronous reset, active-high
sdr_cke  out  1  clock enable
sdr_cs_n  out  1  chip select
sdr_ras_n  out  1  RAS
sdr_cas_n  out  1  CAS
sdr_we_n  out  1  write enable
sdr_ba  out  2  bank address (always 0)
sdr_addr  out  13  address; bit10=1 on PRECHARGE; MODE_REG on LMR; else 0
sdr_dqm  out  SDR_BW  data mask, all ones while cmd_own=1
cmd_own  out  1  this block owns the command bus this cycle
init_done  out  1  init complete, sticky until reset
ref_req  out  1  refresh pending, asking for the bus
ref_gnt  in  1  arbiter grant; all banks' bursts done
ref_pending  out  4  postponed refresh count, 0..8
ref_overrun  out  1  sticky: tick arrived with ref_pending==8

Behaviour:
- Interface decision: one clock (sdram_clk); reset (sdram_reset) is synchronous and active-high. All outputs are registered.
- Command encoding {cs_n,ras_n,cas_n,we_n}: LMR 0000, AREF 0001, PRE 0010, NOP 0111.
- Reset values:
  - cke=0, command=NOP, ba=0, addr=0, dqm=all ones.
  - cmd_own=1, init_done=0, ref_req=0, ref_pending=0, ref_overrun=0.
  - State WAIT_INIT, timer=0.
- Cycle numbering: cycle 0 is the first cycle with sdram_reset low. cke=1 from cycle 0 onward.
- Wait rule: a command issued in cycle k allows the next command no earlier than k+T_x. The wait state holds NOP for T_x-1 cycles.
- Init FSM:
  - WAIT_INIT: NOP for T_INIT cycles.
  - PRE_ALL: PRE with addr[10]=1, issued in cycle T_INIT.
  - WAIT_RP.
  - INIT_AREF: AREF.
  - WAIT_RFC: repeat INIT_AREF until NUM_INIT_REF have been issued.
  - LMR: LMR with addr=MODE_REG, ba=0.
  - WAIT_MRD.
  - IDLE.
- Entering IDLE: init_done=1 and cmd_own=0 in the same cycle. The refresh interval timer starts at 0 that cycle.
- Refresh tick: every REF_INTERVAL cycles after init_done, ref_pending increments. It saturates at 8; a tick at 8 sets ref_overrun.
- Tick while a refresh is in progress: still counted.
- Tick in the same cycle as an AREF issue: ref_pending is unchanged (net zero).
- ref_req = init_done & (ref_pending!=0) & state==IDLE.
- Handshake:
  - ref_gnt is sampled only in IDLE with ref_req=1 and is ignored otherwise.
  - Grant in cycle g: cmd_own=1 and PRE-all issued in cycle g+1.
  - Then WAIT_RP, AREF, and ref_pending decrements in the AREF cycle.
  - Then WAIT_RFC, then IDLE; cmd_own=0 in the first IDLE cycle.
  - One AREF per grant. If more are pending, ref_req reasserts in that IDLE cycle.
- ref_req drops in the cycle after the grant and stays low until back in IDLE.
- Outside owned periods: command=NOP, addr=0, dqm=all ones (the downstream mux ignores them).
- Reset mid-sequence (any state, including mid-refresh): immediate return to reset values next cycle; the full init restarts.
- Timer is CNT_W bits and never wraps: it reloads on each state entry.

Test Plan:
Setup for all scenarios: T_INIT=20, T_RP=2, T_RFC=4, T_MRD=2, NUM_INIT_REF=2, REF_INTERVAL=50.
1. Release reset -> cke=1 at cycle 0; NOP cycles 0-19; PRE (addr=0x400) at cycle 20; AREF at 22 and 26; LMR (addr=0x033) at 30; init_done=1 and cmd_own=0 at cycle 32.
2. Hold ref_gnt=0 after init -> ref_pending=1 at cycle 82; 8 at cycle 432; ref_overrun=1 at cycle 482 with ref_pending still 8.
3. ref_gnt=1 in the first ref_req cycle g -> PRE-all at g+1; AREF at g+3; ref_pending 1->0 at g+3; cmd_own low and IDLE at g+7.
4. ref_pending=2 with grant given -> after one refresh, ref_req=1 again with ref_pending=1; a second grant completes it, ending at ref_pending=0.
5. Assert sdram_reset for 1 cycle during WAIT_RFC of a periodic refresh -> next cycle: cke=0, cmd_own=1, init_done=0, ref_pending=0; PRE at cycle 20 after release.
6. Pulse ref_gnt during init and during WAIT_RP -> ignored; the command sequence is identical to scenario 1 / scenario 3.
